md_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers, sitting in the EX stage beside the ALU. Its HI and LO outputs feed the EX-stage result select mux for MFHI/MFLO, and its busy output feeds the hazard unit. MULT/MULTU/DIV/DIVU run for a fixed number of cycles; MTHI/MTLO write in one cycle.

---
 rtl/md_unit_if.sv | 16 +
 rtl/md_unit.sv | 122 ++++++++++++
 tb/tb_md_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// Operand, launch and result bundle between the EX stage and the multiply/divide unit.
// The pipeline side is the master; md_unit is the slave.
interface md_unit_if;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic [2:0]  op;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output A, output B, output start, output op,
                    input busy, input HI, input LO);
    modport slave  (input A, input B, input start, input op,
                    output busy, output HI, output LO);
endinterface

// File: rtl/md_unit.sv
// Fixed-latency multiply/divide unit with architectural HI/LO registers.
// The full result is computed at launch and held in pend_* until the latency elapses.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [31:0]     pend_hi_reg, pend_hi_next;
    logic [31:0]     pend_lo_reg, pend_lo_next;
    logic            pend_wr_reg, pend_wr_next;
    logic [31:0]     hi_reg, hi_next;
    logic [31:0]     lo_reg, lo_next;

    // Shared datapath: op[0]=0 selects the signed flavour of both MULT and DIV.
    logic            is_signed;
    logic [63:0]     mul_a, mul_b, prod;
    logic            dvd_neg, dvs_neg;
    logic [31:0]     dvd_mag, dvs_mag, dvs_div;
    logic [31:0]     q_mag, r_mag, quo, rem;

    always_comb begin
        is_signed = ~bus.op[0];
        mul_a     = {{32{is_signed & bus.A[31]}}, bus.A};
        mul_b     = {{32{is_signed & bus.B[31]}}, bus.B};
        // Low 64 bits of the sign-extended product are exact for both flavours.
        prod      = mul_a * mul_b;

        dvd_neg   = is_signed & bus.A[31];
        dvs_neg   = is_signed & bus.B[31];
        dvd_mag   = dvd_neg ? (32'd0 - bus.A) : bus.A;
        dvs_mag   = dvs_neg ? (32'd0 - bus.B) : bus.B;
        dvs_div   = (bus.B == 32'd0) ? 32'd1 : dvs_mag;
        q_mag     = dvd_mag / dvs_div;
        r_mag     = dvd_mag % dvs_div;
        quo       = (dvd_neg ^ dvs_neg) ? (32'd0 - q_mag) : q_mag;
        rem       = dvd_neg ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        pend_hi_next = pend_hi_reg;
        pend_lo_next = pend_lo_reg;
        pend_wr_next = pend_wr_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        3'd0, 3'd1: begin
                            pend_hi_next = prod[63:32];
                            pend_lo_next = prod[31:0];
                            pend_wr_next = 1'b1;
                            cnt_next     = CW'(MULT_CYCLES);
                            state_next   = RUN;
                        end
                        3'd2, 3'd3: begin
                            pend_hi_next = rem;
                            pend_lo_next = quo;
                            // A zero divisor still occupies the unit but never writes HI/LO.
                            pend_wr_next = (bus.B != 32'd0);
                            cnt_next     = CW'(DIV_CYCLES);
                            state_next   = RUN;
                        end
                        3'd4:    hi_next = bus.A;
                        3'd5:    lo_next = bus.A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cnt_reg == CW'(1)) begin
                    if (pend_wr_reg) begin
                        hi_next = pend_hi_reg;
                        lo_next = pend_lo_reg;
                    end
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            pend_hi_reg <= '0;
            pend_lo_reg <= '0;
            pend_wr_reg <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pend_hi_reg <= pend_hi_next;
            pend_lo_reg <= pend_lo_next;
            pend_wr_reg <= pend_wr_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
        end
    end

    assign bus.busy = (state_reg == RUN);
    assign bus.HI   = hi_reg;
    assign bus.LO   = lo_reg;
endmodule

// File: tb/tb_md_unit.sv
// Randomized bench for md_unit against an arithmetic reference model of HI/LO and latency.
module tb_md_unit;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] hi_m, lo_m;

    md_unit_if bus ();

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: architectural effect of one accepted launch, plus its busy length.
    task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            output int n);
        longint      p, q, r;
        logic [63:0] pu;
        n = 0;
        case (o)
            3'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                hi_m = p[63:32]; lo_m = p[31:0]; n = MULT_N;
            end
            3'd1: begin
                pu = {32'd0, a} * {32'd0, b};
                hi_m = pu[63:32]; lo_m = pu[31:0]; n = MULT_N;
            end
            3'd2: begin
                if (b != 0) begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    lo_m = q[31:0]; hi_m = r[31:0];
                end
                n = DIV_N;
            end
            3'd3: begin
                if (b != 0) begin
                    lo_m = a / b; hi_m = a % b;
                end
                n = DIV_N;
            end
            3'd4: hi_m = a;
            3'd5: lo_m = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int n, c;
        logic [31:0] hi_old, lo_old;
        hi_old = hi_m;
        lo_old = lo_m;
        model_op(o, a, b, n);
        bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
        tick();
        bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom;
        c = 0;
        while (bus.busy === 1'b1 && c < 64) begin
            check("hold_hi", bus.HI, hi_old);
            check("hold_lo", bus.LO, lo_old);
            tick();
            c++;
        end
        check("busy_cycles", 32'(c), 32'(n));
        check("hi", bus.HI, hi_m);
        check("lo", bus.LO, lo_m);
        $display("op=%0d A=%h B=%h busy=%0d HI=%h LO=%h", o, a, b, c, bus.HI, bus.LO);
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int c;
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 3'd0; bus.A = '0; bus.B = '0;
        hi_m = '0; lo_m = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_hi", bus.HI, 32'd0);
        check("rst_lo", bus.LO, 32'd0);

        run_op(3'd6, 32'hCAFE_F00D, 32'h1);
        run_op(3'd7, 32'hCAFE_F00D, 32'h1);

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3);
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd3, 32'd7, 32'd2);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd4, 32'h1111_1111, 32'd0);
        run_op(3'd5, 32'h2222_2222, 32'd0);
        run_op(3'd2, 32'h1234_5678, 32'd0);
        run_op(3'd3, 32'h1234_5678, 32'd0);

        // Launches while busy must be ignored, including MTLO.
        model_op(3'd0, 32'd5, 32'd7, c);
        bus.start = 1'b1; bus.op = 3'd0; bus.A = 32'd5; bus.B = 32'd7;
        tick();
        check("inflight_busy1", {31'd0, bus.busy}, 32'd1);
        bus.op = 3'd5; bus.A = 32'hDEAD_BEEF;
        tick();
        bus.op = 3'd0; bus.A = 32'd3; bus.B = 32'd3;
        tick();
        bus.start = 1'b0;
        c = 2;
        while (bus.busy === 1'b1 && c < 64) begin
            tick();
            c++;
        end
        check("inflight_cycles", 32'(c), 32'(MULT_N));
        check("inflight_hi", bus.HI, hi_m);
        check("inflight_lo", bus.LO, lo_m);
        $display("op=0 A=00000005 B=00000007 with ignored launches busy=%0d HI=%h LO=%h",
                 c, bus.HI, bus.LO);
        run_op(3'd0, 32'h1234_5678, 32'd9);

        // Reset during a divide, together with a competing MTHI launch.
        bus.start = 1'b1; bus.op = 3'd2; bus.A = 32'd100; bus.B = 32'd7;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1; bus.start = 1'b1; bus.op = 3'd4; bus.A = 32'h5555_5555;
        tick();
        reset = 1'b0; bus.start = 1'b0;
        hi_m = '0; lo_m = '0;
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_hi", bus.HI, 32'd0);
        check("midrst_lo", bus.LO, 32'd0);
        for (int i = 0; i < 15; i++) begin
            tick();
            check("midrst_idle", {31'd0, bus.busy}, 32'd0);
        end
        check("midrst_hi_late", bus.HI, 32'd0);
        check("midrst_lo_late", bus.LO, 32'd0);
        $display("reset mid-DIV busy=%0d HI=%h LO=%h", bus.busy, bus.HI, bus.LO);

        for (int i = 0; i < 150; i++) begin
            logic [2:0]  o;
            logic [31:0] a, b;
            o = 3'($urandom_range(0, 7));
            a = rnd_word();
            b = rnd_word();
            run_op(o, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
